// File: rtl/wave_dac_pkg.sv
// Shared types and constants for the wave_dac sequencing controller.
// Optional fade sequencing is enabled by defining WAVE_CTRL_FADE_EN.
package wave_dac_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int AMP_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_FADE_OUT = 3'd2,
    ST_SWITCH   = 3'd3,
    ST_FADE_IN  = 3'd4
  } state_t;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  // One fade step towards zero, saturating so the ramp never wraps.
  function automatic logic [AMP_W-1:0] ramp_down(input logic [AMP_W-1:0] amp,
                                                 input logic [AMP_W-1:0] step);
    return (amp <= step) ? {AMP_W{1'b0}} : amp - step;
  endfunction

  function automatic logic [AMP_W-1:0] ramp_up(input logic [AMP_W-1:0] amp,
                                               input logic [AMP_W-1:0] target,
                                               input logic [AMP_W-1:0] step);
    return ((amp >= target) || ((target - amp) <= step)) ? target : amp + step;
  endfunction

endpackage

// File: rtl/wave_dac_ctrl_tick.sv
// Sample tick divider: free-running 0..SAMPLE_DIV-1 counter, strobe on the last count.
module wave_tick_div #(
  parameter int SAMPLE_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sample_en
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter; never realigned, only the strobe is gated.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign sample_en = en && (cnt_r == LAST);

endmodule

// File: rtl/wave_dac_ctrl.sv
// Sequencing controller for the wave_dac datapath: command intake, phase accumulator,
// and glitch-free amplitude ramps. Define WAVE_CTRL_FADE_EN to enable fade sequencing.
module wave_dac_ctrl
  import wave_dac_pkg::*;
#(
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int SAMPLE_DIV = 4,
  parameter int FADE_STEP  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_wave,
  input  logic [PHASE_W-1:0] cmd_step,
  input  logic [AMP_W-1:0]   cmd_amp,
  output logic [7:0]         phase_addr,
  output logic [1:0]         wave_sel,
  output logic [AMP_W-1:0]   amp_out,
  output logic               sample_en,
  output logic               busy
);

  localparam logic [AMP_W-1:0] FADE_STEP_C = AMP_W'(FADE_STEP);

  state_t             state_r, state_s;
  logic [PHASE_W-1:0] acc_r, step_r, sh_step_r;
  logic [1:0]         wave_r, sh_wave_r;
  logic [AMP_W-1:0]   amp_r, amp_s, tgt_r, sh_amp_r;
  logic               busy_r, ready_r;
  logic               tick_s, tick_en_s, accept_s, load_act_s;

  assign tick_en_s = (state_r != ST_IDLE);
  assign accept_s  = cmd_valid && ready_r;

  wave_tick_div #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (tick_en_s),
    .sample_en (tick_s)
  );

  // Next state, next amplitude, and when the shadow command becomes active.
  always_comb begin
    state_s    = state_r;
    amp_s      = amp_r;
    load_act_s = 1'b0;
    case (state_r)
`ifdef WAVE_CTRL_FADE_EN
      ST_IDLE: state_s = run ? ST_FADE_IN : ST_IDLE;
      ST_RUN:  state_s = (accept_s || !run) ? ST_FADE_OUT : ST_RUN;
      ST_FADE_OUT: begin
        amp_s = tick_s ? ramp_down(amp_r, FADE_STEP_C) : amp_r;
        // Load on the exit edge so SWITCH already shows the new shape.
        if (tick_s && (amp_s == '0)) begin
          state_s    = ST_SWITCH;
          load_act_s = 1'b1;
        end else begin
          state_s = ST_FADE_OUT;
        end
      end
      ST_SWITCH: begin
        load_act_s = 1'b1;
        state_s    = run ? ST_FADE_IN : ST_IDLE;
      end
      ST_FADE_IN: begin
        if (!run) begin
          state_s = ST_FADE_OUT;
        end else if (tick_s) begin
          amp_s   = ramp_up(amp_r, tgt_r, FADE_STEP_C);
          state_s = (amp_s == tgt_r) ? ST_RUN : ST_FADE_IN;
        end else begin
          state_s = ST_FADE_IN;
        end
      end
`else
      ST_IDLE: state_s = run ? ST_SWITCH : ST_IDLE;
      ST_RUN: begin
        if (accept_s) begin
          state_s = ST_SWITCH;
        end else if (!run) begin
          state_s = ST_IDLE;
          amp_s   = '0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_SWITCH: begin
        load_act_s = 1'b1;
        amp_s      = sh_amp_r;
        state_s    = ST_RUN;
      end
`endif
      default: begin
        state_s = ST_IDLE;
        amp_s   = '0;
      end
    endcase
  end

  // State, amplitude and the status flags that travel with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      amp_r   <= '0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      amp_r   <= amp_s;
      busy_r  <= (state_s inside {ST_FADE_OUT, ST_SWITCH, ST_FADE_IN});
      ready_r <= (state_s inside {ST_IDLE, ST_RUN});
    end
  end

  // Shadow command registers, written on every accepted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_wave_r <= 2'd0;
      sh_step_r <= '0;
      sh_amp_r  <= '0;
    end else if (accept_s) begin
      sh_wave_r <= cmd_wave;
      sh_step_r <= cmd_step;
      sh_amp_r  <= cmd_amp;
    end
  end

  // Active registers: direct load in IDLE, otherwise only from the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wave_r <= 2'd0;
      step_r <= '0;
      tgt_r  <= '0;
    end else if (accept_s && (state_r == ST_IDLE)) begin
      wave_r <= cmd_wave;
      step_r <= cmd_step;
      tgt_r  <= cmd_amp;
    end else if (load_act_s) begin
      wave_r <= sh_wave_r;
      step_r <= sh_step_r;
      tgt_r  <= sh_amp_r;
    end
  end

  // Phase accumulator; wraps silently, held at zero while idle or switching.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= '0;
    end else if ((state_r == ST_IDLE) || (state_r == ST_SWITCH) || load_act_s) begin
      acc_r <= '0;
    end else if (tick_s) begin
      acc_r <= acc_r + step_r;
    end
  end

  assign phase_addr = acc_r[PHASE_W-1 -: 8];
  assign wave_sel   = wave_r;
  assign amp_out    = amp_r;
  assign sample_en  = tick_s;
  assign busy       = busy_r;
  assign cmd_ready  = ready_r;

endmodule

// File: tb/tb_wave_dac_ctrl.sv
// Self-checking bench for wave_dac_ctrl: table vectors, directed corner sequences and
// randomized traffic against a behavioural model. Honours WAVE_CTRL_FADE_EN.
module tb_wave_dac_ctrl;

  localparam int DIV = 4;
  localparam int FS  = 16;

  logic        clk = 1'b0;
  logic        rst, run, cmd_valid;
  logic [1:0]  cmd_wave;
  logic [15:0] cmd_step;
  logic [7:0]  cmd_amp;
  logic        cmd_ready, sample_en, busy;
  logic [7:0]  phase_addr, amp_out;
  logic [1:0]  wave_sel;

  always #5 clk = ~clk;

  wave_dac_ctrl #(.PHASE_W(16), .SAMPLE_DIV(DIV), .FADE_STEP(FS)) dut (
    .clk(clk), .rst(rst), .run(run), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wave(cmd_wave), .cmd_step(cmd_step), .cmd_amp(cmd_amp),
    .phase_addr(phase_addr), .wave_sel(wave_sel), .amp_out(amp_out),
    .sample_en(sample_en), .busy(busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Behavioural model: "on" = producing output, ramp = -1 falling / +1 rising / 0 steady,
  // sw = one-cycle swap of the pending command into the live one.
  int m_cnt, m_ramp, m_acc, m_amp, m_tgt, m_wave, m_step, s_wave, s_step, s_amp;
  bit m_on, m_sw;

  function automatic bit m_ready();
    return !m_on || (m_ramp == 0 && !m_sw);
  endfunction

  task automatic take_shadow();
    m_wave = s_wave; m_step = s_step; m_tgt = s_amp;
  endtask

  task automatic model_step();
    bit tick, accept;
    if (rst) begin
      m_cnt = 0; m_ramp = 0; m_acc = 0; m_amp = 0; m_tgt = 0; m_wave = 0; m_step = 0;
      s_wave = 0; s_step = 0; s_amp = 0; m_on = 0; m_sw = 0;
      return;
    end
    tick   = m_on && (m_cnt == DIV - 1);
    accept = cmd_valid && m_ready();
    m_cnt  = (m_cnt + 1) % DIV;
    if (!m_on || m_sw) m_acc = 0;
    else if (tick) m_acc = (m_acc + m_step) % 65536;
    if (accept) begin s_wave = cmd_wave; s_step = cmd_step; s_amp = cmd_amp; end
    if (!m_on) begin
      if (accept) take_shadow();
      if (run) begin
        m_on = 1;
`ifdef WAVE_CTRL_FADE_EN
        m_ramp = 1;
`else
        m_sw = 1;
`endif
      end
    end else if (m_sw) begin
      take_shadow();
      m_sw = 0;
`ifdef WAVE_CTRL_FADE_EN
      if (run) m_ramp = 1; else m_on = 0;
`else
      m_amp = m_tgt;
`endif
    end else if (m_ramp == 0) begin
`ifdef WAVE_CTRL_FADE_EN
      if (accept || !run) m_ramp = -1;
`else
      if (accept) m_sw = 1;
      else if (!run) begin m_on = 0; m_amp = 0; end
`endif
    end else if (m_ramp < 0) begin
      if (tick) begin
        m_amp = (m_amp <= FS) ? 0 : m_amp - FS;
        if (m_amp == 0) begin m_ramp = 0; m_sw = 1; take_shadow(); m_acc = 0; end
      end
    end else begin
      if (!run) m_ramp = -1;
      else if (tick) begin
        m_amp = (m_tgt - m_amp <= FS) ? m_tgt : m_amp + FS;
        if (m_amp == m_tgt) m_ramp = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("amp_out", amp_out, m_amp);
    chk("wave_sel", wave_sel, m_wave);
    chk("phase_addr", phase_addr, (m_acc >> 8) & 255);
    chk("cmd_ready", cmd_ready, m_ready());
    chk("busy", busy, m_sw || (m_ramp != 0));
    chk("sample_en", sample_en, m_on && (m_cnt == DIV - 1));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; cmd_valid = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] w, input logic [15:0] s, input logic [7:0] a);
    cmd_valid = 1'b1; cmd_wave = w; cmd_step = s; cmd_amp = a;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic settle();
    step();
    for (int i = 0; i < 400 && busy; i++) step();
    chk("settle_busy", busy, 0);
  endtask

  task automatic next_tick_edge();
    bit se;
    bit seen = 0;
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      se = sample_en;
      step();
      if (se) begin seen = 1; break; end
    end
    chk("tick_seen", seen, 1);
  endtask

  typedef struct {
    logic [1:0]  wave;
    logic [15:0] stp;
    logic [7:0]  amp;
    int          fade_ticks;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n;
    bit se, b;
    logic [7:0] p0;
    rst = 1'b1; run = 1'b0; cmd_valid = 1'b0; cmd_wave = 2'd0; cmd_step = 16'd0; cmd_amp = 8'd0;
    tbl[0] = '{2'd2, 16'h0100, 8'h45, 5};
    tbl[1] = '{2'd0, 16'h1234, 8'h80, 8};
    tbl[2] = '{2'd1, 16'h0001, 8'h10, 1};
    tbl[3] = '{2'd3, 16'hFFFF, 8'h00, 1};
    tbl[4] = '{2'd2, 16'h8000, 8'hFF, 16};
    tbl[5] = '{2'd1, 16'h0040, 8'h11, 2};

    // Reset values and idle tick gating
    do_reset();
    chk("rst_amp", amp_out, 8'h00);
    chk("rst_phase", phase_addr, 8'h00);
    chk("rst_wave", wave_sel, 2'd0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    for (int i = 0; i < 2 * DIV; i++) begin
      step();
      chk("idle_sample_en", sample_en, 1'b0);
    end

    // Table: start from IDLE with a command, measure the ramp-in
    for (int t = 0; t < 6; t++) begin
      do_reset();
      send_cmd(tbl[t].wave, tbl[t].stp, tbl[t].amp);
      run = 1'b1;
      n = 0;
      for (int i = 0; i < 300; i++) begin
        se = sample_en; b = busy;
        step();
`ifdef WAVE_CTRL_FADE_EN
        if (se && b) n++;
`else
        if (b) n++;
`endif
        if (i > 0 && !busy) break;
      end
`ifdef WAVE_CTRL_FADE_EN
      chk("tbl_ramp_len", n, tbl[t].fade_ticks);
`else
      chk("tbl_switch_len", n, 1);
`endif
      chk("tbl_amp", amp_out, tbl[t].amp);
      chk("tbl_wave", wave_sel, tbl[t].wave);
      chk("tbl_ready", cmd_ready, 1'b1);
      next_tick_edge();
`ifdef WAVE_CTRL_FADE_EN
      chk("tbl_phase", phase_addr, ((tbl[t].stp * (tbl[t].fade_ticks + 1)) >> 8) & 255);
`else
      chk("tbl_phase", phase_addr, (tbl[t].stp >> 8) & 255);
`endif
    end

    // Phase wrap with a half-turn step
    do_reset();
    send_cmd(2'd0, 16'h8000, 8'h20);
    run = 1'b1;
    settle();
    p0 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2 * DIV && !sample_en; i++) step();
      if (k == 0) begin
        p0 = phase_addr;
        chk("wrap_low_bits", p0 & 8'h7F, 8'h00);
      end else begin
        chk("wrap_phase", phase_addr, (k % 2 == 1) ? (p0 ^ 8'h80) : p0);
      end
      step();
    end

`ifdef WAVE_CTRL_FADE_EN
    // Shape switch at amplitude 0x80
    do_reset();
    send_cmd(2'd0, 16'h0100, 8'h80);
    run = 1'b1;
    settle();
    chk("sw_start_amp", amp_out, 8'h80);
    send_cmd(2'd1, 16'h0200, 8'h40);
    chk("sw_ready_low", cmd_ready, 1'b0);
    chk("sw_busy", busy, 1'b1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      se = sample_en;
      step();
      if (se) n++;
      if (amp_out == 8'h00) break;
    end
    chk("sw_fade_out_ticks", n, 8);
    chk("sw_phase_zero", phase_addr, 8'h00);
    chk("sw_wave_new", wave_sel, 2'd1);
    chk("sw_busy_switch", busy, 1'b1);
    step();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      se = sample_en;
      step();
      if (se) n++;
      if (!busy) break;
    end
    chk("sw_fade_in_ticks", n, 4);
    chk("sw_final_amp", amp_out, 8'h40);

    // Run drop mid fade-in, with an ignored command pulse
    do_reset();
    send_cmd(2'd2, 16'h0100, 8'h80);
    run = 1'b1;
    for (int i = 0; i < 200 && amp_out != 8'h30; i++) step();
    chk("drop_reach_30", amp_out, 8'h30);
    run = 1'b0;
    cmd_valid = 1'b1; cmd_wave = 2'd3; cmd_amp = 8'h11; cmd_step = 16'h0777;
    step();
    cmd_valid = 1'b0;
    chk("drop_hold_amp", amp_out, 8'h30);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      se = sample_en;
      step();
      if (se) n++;
      if (amp_out == 8'h00) break;
    end
    chk("drop_fade_ticks", n, 3);
    chk("drop_switch_busy", busy, 1'b1);
    chk("drop_switch_wave", wave_sel, 2'd2);
    step();
    chk("drop_idle_busy", busy, 1'b0);
    chk("drop_idle_ready", cmd_ready, 1'b1);
    chk("drop_idle_wave", wave_sel, 2'd2);
    run = 1'b1;
    settle();
    chk("drop_target_kept", amp_out, 8'h80);

    // Reset asserted in the middle of a fade-out
    do_reset();
    send_cmd(2'd3, 16'h0300, 8'h80);
    run = 1'b1;
    settle();
    run = 1'b0;
    step();
    next_tick_edge();
    chk("rstmid_in_fade", amp_out, 8'h70);
    rst = 1'b1;
    step();
    chk("rstmid_amp", amp_out, 8'h00);
    chk("rstmid_wave", wave_sel, 2'd0);
    chk("rstmid_phase", phase_addr, 8'h00);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_ready", cmd_ready, 1'b1);
    rst = 1'b0;
`else
    // Command in RUN without fades: swap lands one edge after acceptance
    do_reset();
    send_cmd(2'd1, 16'h0100, 8'h20);
    run = 1'b1;
    settle();
    send_cmd(2'd2, 16'h0500, 8'h55);
    chk("nf_busy", busy, 1'b1);
    chk("nf_ready", cmd_ready, 1'b0);
    chk("nf_old_wave", wave_sel, 2'd1);
    chk("nf_old_amp", amp_out, 8'h20);
    step();
    chk("nf_new_wave", wave_sel, 2'd2);
    chk("nf_new_amp", amp_out, 8'h55);
    chk("nf_busy_done", busy, 1'b0);
    run = 1'b0;
    step();
    chk("nf_stop_amp", amp_out, 8'h00);
    chk("nf_stop_ready", cmd_ready, 1'b1);
    for (int i = 0; i < DIV; i++) begin
      step();
      chk("nf_stop_sample_en", sample_en, 1'b0);
    end
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) run = ~run;
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_wave  = 2'($urandom_range(0, 3));
      cmd_step  = 16'($urandom);
      cmd_amp   = 8'($urandom);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
